id_stage_sequencer: RTL and testbench

- Decode-stage sequencer between fetch (IF) and execute (EX) in the RV32IM pipeline.
- Accepts instructions from IF through a valid/ready handshake and holds the ID pipeline register.
- Decodes the opcode into the 3-bit IMMEDIATE_TYPE select that drives the immediate generator.
- Inserts load-use bubbles and applies branch/jump flushes.

---
 rtl/id_stage_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_id_stage_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_sequencer.sv
// id_stage_sequencer
// Decode-stage pipeline register between IF and EX. Accepts instructions over a
// valid/ready handshake, decodes the immediate-format select, flags unknown
// opcodes, stalls IF for load-use hazards and applies branch/jump flushes.
module id_stage_sequencer #(
  parameter int XLEN             = 32,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            IF_VALID,
  input  logic [XLEN-1:0] IF_INSTRUCTION,
  input  logic [XLEN-1:0] IF_PC,
  output logic            IF_READY,
  input  logic            EX_READY,
  input  logic            FLUSH,
  output logic            ID_VALID,
  output logic [XLEN-1:0] ID_INSTRUCTION,
  output logic [XLEN-1:0] ID_PC,
  output logic [2:0]      IMMEDIATE_TYPE,
  output logic            ID_ILLEGAL
);

  // addi x0,x0,0 -- what an empty ID register presents downstream
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_J    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_B    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  // Value the bubble counter reloads to when a load leaves for EX (0..3)
  localparam logic [1:0] BUBBLE_RELOAD = 2'(LOAD_USE_BUBBLES);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] instr_reg, instr_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [2:0]      imm_type_reg, imm_type_next;
  logic            illegal_reg, illegal_next;
  logic [1:0]      bubble_cnt_reg, bubble_cnt_next;
  logic [4:0]      pend_rd_reg, pend_rd_next;

  logic [6:0]      if_opcode;
  logic [2:0]      if_imm_type;
  logic            if_illegal;
  logic            uses_rs1;
  logic            uses_rs2;
  logic [4:0]      src_reg [2];
  logic [1:0]      src_used;
  logic [1:0]      src_match;
  logic            hazard;
  logic            accept;
  logic            consume;
  logic [6:0]      id_opcode;
  logic [4:0]      id_rd;
  logic            id_load_retire;

  assign if_opcode = IF_INSTRUCTION[6:0];

  // Opcode to immediate-format select; anything outside RV32IM is flagged illegal
  always_comb begin
    if_imm_type = IMM_NONE;
    if_illegal  = 1'b0;
    case (if_opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: if_imm_type = IMM_I;
      OP_STORE:                                     if_imm_type = IMM_S;
      OP_JAL:                                       if_imm_type = IMM_J;
      OP_LUI, OP_AUIPC:                             if_imm_type = IMM_U;
      OP_BRANCH:                                    if_imm_type = IMM_B;
      OP_REG:                                       if_imm_type = IMM_NONE;
      default: begin
        if_imm_type = IMM_NONE;
        if_illegal  = 1'b1;
      end
    endcase
  end

  // U and J formats carry no rs1; only S, B and register-register ops read rs2
  assign uses_rs1 = (if_imm_type != IMM_U) && (if_imm_type != IMM_J);
  assign uses_rs2 = (if_imm_type == IMM_S) || (if_imm_type == IMM_B) || (if_opcode == OP_REG);

  assign src_reg[0] = IF_INSTRUCTION[19:15];
  assign src_reg[1] = IF_INSTRUCTION[24:20];
  assign src_used   = {uses_rs2, uses_rs1};

  // Per-source comparison against the destination of the load now in EX; x0 never matches
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src_match
      assign src_match[gi] = src_used[gi] && (src_reg[gi] != 5'd0) &&
                             (src_reg[gi] == pend_rd_reg);
    end
  endgenerate

  // The counter only becomes non-zero after a load retires, so a zero reload disables stalls
  assign hazard = (bubble_cnt_reg != 2'd0) && IF_VALID && (|src_match);

  assign ID_VALID = (state_reg == ST_FULL);
  assign IF_READY = RESET_N && !FLUSH && !hazard && (!ID_VALID || EX_READY);
  assign accept   = IF_VALID && IF_READY;
  // A flushed instruction is killed, never handed to EX
  assign consume  = ID_VALID && EX_READY && !FLUSH;

  assign id_opcode      = instr_reg[6:0];
  assign id_rd          = instr_reg[11:7];
  assign id_load_retire = consume && (id_opcode == OP_LOAD) && (id_rd != 5'd0);

  // Occupancy next-state: flush empties, a transfer fills, a bare consume drains
  always_comb begin
    state_next = state_reg;
    if (FLUSH) begin
      state_next = ST_EMPTY;
    end else if (accept) begin
      state_next = ST_FULL;
    end else if (consume) begin
      state_next = ST_EMPTY;
    end
  end

  // ID register contents: load on transfer, NOP when the slot empties, hold otherwise
  always_comb begin
    instr_next    = instr_reg;
    pc_next       = pc_reg;
    imm_type_next = imm_type_reg;
    illegal_next  = illegal_reg;
    if (FLUSH) begin
      instr_next = NOP;
    end else if (accept) begin
      instr_next    = IF_INSTRUCTION;
      pc_next       = IF_PC;
      imm_type_next = if_imm_type;
      illegal_next  = if_illegal;
    end else if (consume) begin
      instr_next = NOP;
    end
  end

  // Load-use tracking: a retiring load reloads the counter, otherwise it counts EX cycles down
  always_comb begin
    bubble_cnt_next = bubble_cnt_reg;
    pend_rd_next    = pend_rd_reg;
    if (FLUSH) begin
      bubble_cnt_next = 2'd0;
      pend_rd_next    = 5'd0;
    end else if (id_load_retire) begin
      bubble_cnt_next = BUBBLE_RELOAD;
      pend_rd_next    = id_rd;
    end else if (EX_READY && (bubble_cnt_reg != 2'd0)) begin
      bubble_cnt_next = bubble_cnt_reg - 2'd1;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // ID pipeline register and hazard tracking registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      instr_reg      <= NOP;
      pc_reg         <= '0;
      imm_type_reg   <= IMM_I;
      illegal_reg    <= 1'b0;
      bubble_cnt_reg <= 2'd0;
      pend_rd_reg    <= 5'd0;
    end else begin
      instr_reg      <= instr_next;
      pc_reg         <= pc_next;
      imm_type_reg   <= imm_type_next;
      illegal_reg    <= illegal_next;
      bubble_cnt_reg <= bubble_cnt_next;
      pend_rd_reg    <= pend_rd_next;
    end
  end

  assign ID_INSTRUCTION = instr_reg;
  assign ID_PC          = pc_reg;
  assign IMMEDIATE_TYPE = imm_type_reg;
  assign ID_ILLEGAL     = illegal_reg;

endmodule

// File: tb/tb_id_stage_sequencer.sv
// tb_id_stage_sequencer
// Scoreboarded bench: directed sequences followed by random traffic. A reference
// model tracks ID occupancy and the pending load, predicts IF_READY and pushes
// each accepted instruction; a monitor checks whatever ID presents.
module tb_id_stage_sequencer;

  localparam int          LUB = 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        IF_VALID = 1'b0;
  logic [31:0] IF_INSTRUCTION = 32'h0;
  logic [31:0] IF_PC = 32'h0;
  logic        IF_READY;
  logic        EX_READY = 1'b0;
  logic        FLUSH = 1'b0;
  logic        ID_VALID;
  logic [31:0] ID_INSTRUCTION;
  logic [31:0] ID_PC;
  logic [2:0]  IMMEDIATE_TYPE;
  logic        ID_ILLEGAL;

  always #5 CLK = ~CLK;

  id_stage_sequencer #(
    .XLEN(32),
    .LOAD_USE_BUBBLES(LUB)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .IF_VALID(IF_VALID),
    .IF_INSTRUCTION(IF_INSTRUCTION),
    .IF_PC(IF_PC),
    .IF_READY(IF_READY),
    .EX_READY(EX_READY),
    .FLUSH(FLUSH),
    .ID_VALID(ID_VALID),
    .ID_INSTRUCTION(ID_INSTRUCTION),
    .ID_PC(ID_PC),
    .IMMEDIATE_TYPE(IMMEDIATE_TYPE),
    .ID_ILLEGAL(ID_ILLEGAL)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  imm;
    logic        ill;
  } item_t;

  item_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: is ID occupied, what it holds, load-use counter and register
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = NOP;
  int          m_cnt = 0;
  logic [4:0]  m_pd = 5'd0;
  logic [31:0] pc_gen = 32'h0000_1000;

  bit [2:0] imm_tab[bit [6:0]];
  bit [6:0] op_list[11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23,
                            7'h6F, 7'h37, 7'h17, 7'h63, 7'h33};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_type(logic [6:0] op);
    if (imm_tab.exists(op)) return imm_tab[op];
    return 3'b111;
  endfunction

  function automatic bit exp_ill(logic [6:0] op);
    return !imm_tab.exists(op);
  endfunction

  function automatic bit model_hazard();
    logic [6:0] op;
    logic [2:0] t;
    logic [4:0] s1;
    logic [4:0] s2;
    bit         u1;
    bit         u2;
    op = IF_INSTRUCTION[6:0];
    t  = exp_type(op);
    s1 = IF_INSTRUCTION[19:15];
    s2 = IF_INSTRUCTION[24:20];
    u1 = (t != 3'b011) && (t != 3'b010);
    u2 = (t == 3'b001) || (t == 3'b100) || (op == 7'h33);
    return (m_cnt > 0) && IF_VALID &&
           ((u1 && s1 != 5'd0 && s1 == m_pd) || (u2 && s2 != 5'd0 && s2 == m_pd));
  endfunction

  function automatic bit exp_ready();
    return !FLUSH && !model_hazard() && (!m_valid || EX_READY);
  endfunction

  // Advance the model across one rising edge using the inputs held during the cycle
  task automatic model_update();
    bit rdy;
    bit cons;
    item_t it;
    rdy = exp_ready();
    if (FLUSH) begin
      if (m_valid && sb_q.size() > 0) void'(sb_q.pop_front());
      m_valid = 1'b0;
      m_instr = NOP;
      m_cnt   = 0;
      m_pd    = 5'd0;
    end else begin
      cons = m_valid && EX_READY;
      if (cons && m_instr[6:0] == 7'h03 && m_instr[11:7] != 5'd0) begin
        m_cnt = LUB;
        m_pd  = m_instr[11:7];
      end else if (EX_READY && m_cnt > 0) begin
        m_cnt--;
      end
      if (IF_VALID && rdy) begin
        m_valid  = 1'b1;
        m_instr  = IF_INSTRUCTION;
        it.instr = IF_INSTRUCTION;
        it.pc    = IF_PC;
        it.imm   = exp_type(IF_INSTRUCTION[6:0]);
        it.ill   = exp_ill(IF_INSTRUCTION[6:0]);
        sb_q.push_back(it);
      end else if (cons) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
    end
  endtask

  // One clock of stimulus: update model at the edge, drive, check handshake at the falling edge
  task automatic cycle(bit v, logic [31:0] ins, bit exr, bit fl);
    @(posedge CLK);
    model_update();
    #1;
    IF_VALID       = v;
    IF_INSTRUCTION = ins;
    IF_PC          = pc_gen;
    pc_gen         = pc_gen + 32'd4;
    EX_READY       = exr;
    FLUSH          = fl;
    @(negedge CLK);
    chk("if_ready", 32'(IF_READY), 32'(exp_ready()));
    chk("id_valid", 32'(ID_VALID), 32'(m_valid));
    if (!m_valid) chk("empty_nop", ID_INSTRUCTION, NOP);
  endtask

  // Asynchronous reset between edges while EX would otherwise be ready
  task automatic reset_pulse();
    @(posedge CLK);
    model_update();
    #1;
    IF_VALID = 1'b0;
    FLUSH    = 1'b0;
    EX_READY = 1'b1;
    #1;
    RESET_N = 1'b0;
    #1;
    chk("rst_id_valid", 32'(ID_VALID), 32'd0);
    chk("rst_instr", ID_INSTRUCTION, NOP);
    chk("rst_pc", ID_PC, 32'd0);
    chk("rst_imm", 32'(IMMEDIATE_TYPE), 32'd0);
    chk("rst_ill", 32'(ID_ILLEGAL), 32'd0);
    chk("rst_if_ready", 32'(IF_READY), 32'd0);
    m_valid = 1'b0;
    m_instr = NOP;
    m_cnt   = 0;
    m_pd    = 5'd0;
    sb_q.delete();
    $display("[%0t] reset pulse", $time);
    @(negedge CLK);
    chk("rst_if_ready_hold", 32'(IF_READY), 32'd0);
    #2;
    RESET_N = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    int          sel;
    r   = $urandom();
    sel = $urandom_range(0, 15);
    if (sel < 4) op = 7'h03;
    else if (sel == 15) op = 7'($urandom());
    else op = op_list[$urandom_range(0, 10)];
    return {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            r[14:12], 5'($urandom_range(0, 3)), op};
  endfunction

  // Monitor: whatever ID presents must match the oldest live expectation
  always @(negedge CLK) begin
    item_t e;
    if (RESET_N && ID_VALID) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: ID_VALID=1 instr=%08h but nothing expected at %0t",
                 ID_INSTRUCTION, $time);
      end else begin
        e = sb_q[0];
        chk("id_instr", ID_INSTRUCTION, e.instr);
        chk("id_pc", ID_PC, e.pc);
        chk("imm_type", 32'(IMMEDIATE_TYPE), 32'(e.imm));
        chk("id_illegal", 32'(ID_ILLEGAL), 32'(e.ill));
        if (EX_READY && !FLUSH) begin
          void'(sb_q.pop_front());
          $display("[%0t] EX took pc=%08h instr=%08h imm=%03b ill=%0b",
                   $time, ID_PC, ID_INSTRUCTION, IMMEDIATE_TYPE, ID_ILLEGAL);
        end
      end
    end
  end

  initial begin
    imm_tab[7'h13] = 3'b000; imm_tab[7'h03] = 3'b000; imm_tab[7'h67] = 3'b000;
    imm_tab[7'h73] = 3'b000; imm_tab[7'h0F] = 3'b000; imm_tab[7'h23] = 3'b001;
    imm_tab[7'h6F] = 3'b010; imm_tab[7'h37] = 3'b011; imm_tab[7'h17] = 3'b011;
    imm_tab[7'h63] = 3'b100; imm_tab[7'h33] = 3'b111;

    #1 RESET_N = 1'b0;
    #2;
    chk("init_id_valid", 32'(ID_VALID), 32'd0);
    chk("init_instr", ID_INSTRUCTION, NOP);
    chk("init_pc", ID_PC, 32'd0);
    chk("init_imm", 32'(IMMEDIATE_TYPE), 32'd0);
    chk("init_ill", 32'(ID_ILLEGAL), 32'd0);
    chk("init_if_ready", 32'(IF_READY), 32'd0);
    @(negedge CLK);
    #2 RESET_N = 1'b1;

    // Back-to-back stream covering every immediate format
    cycle(1, 32'h00500093, 1, 0);
    cycle(1, 32'h00112223, 1, 0);
    cycle(1, 32'h008000EF, 1, 0);
    cycle(1, 32'h000012B7, 1, 0);
    cycle(1, 32'h00208463, 1, 0);
    cycle(1, 32'h02208033, 1, 0);
    cycle(0, NOP, 1, 0);

    // lw x5 then dependent add x6,x5,x2, then independent add x6,x7,x2
    cycle(1, 32'h0000A283, 1, 0);
    cycle(0, NOP, 1, 0);
    cycle(1, 32'h00228333, 1, 0);
    cycle(1, 32'h00228333, 1, 0);
    cycle(1, 32'h0000A283, 1, 0);
    cycle(0, NOP, 1, 0);
    cycle(1, 32'h00238333, 1, 0);
    cycle(0, NOP, 1, 0);

    // EX back-pressure for three cycles with ID full
    cycle(1, 32'h00500093, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 32'h00112223, 0, 0);
    cycle(1, 32'h00112223, 1, 0);
    cycle(0, NOP, 1, 0);

    // Flush while ID is full and a load hazard is pending, EX stalled
    cycle(1, 32'h0000A283, 1, 0);
    cycle(1, 32'h00100493, 1, 0);
    cycle(1, 32'h00228333, 0, 1);
    cycle(1, 32'h00228333, 1, 0);
    cycle(0, NOP, 1, 0);

    // Unknown opcode still flows
    cycle(1, 32'h0000007F, 1, 0);
    cycle(0, NOP, 1, 0);

    // Reset while ID holds an instruction
    cycle(1, 32'h00500093, 0, 0);
    reset_pulse();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse();
      end else begin
        cycle($urandom_range(0, 3) != 0, rand_instr(),
              $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      end
    end

    for (int i = 0; i < 3; i++) cycle(0, NOP, 1, 0);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
